// File: rtl/lab02_dff_checker.sv
// lab02_dff_checker
//
// Response monitor for the lab02 D flip-flop. It watches the data bit driven
// into the flip-flop (din) and the flip-flop outputs (q, qn). After a start
// request it spends one ARM cycle capturing the first expected value. It then
// checks NUM_CHECKS consecutive edges, requiring that q equals din as sampled
// one edge earlier. At the end it reports pass/fail, an error count and the
// index of the first failing check.
//
// Optional feature: define LAB02_CHK_NOUT_EN to also require qn == ~q on every
// check edge. If both q and qn are wrong in the same cycle, that cycle still
// counts as a single error. Without the macro, qn is ignored.
//
// Parameters:
//   NUM_CHECKS  compared cycles per run, 1 .. 2^CNT_W-1
//   CNT_W       width of the check index and error counters
//
// Ports:
//   clk        rising-edge clock shared with the flip-flop under test
//   reset      synchronous, active-high reset
//   start      run request (ignored while ARM/CHECK)
//   din        data bit driven into the flip-flop
//   q, qn      flip-flop out / nout
//   busy       high in ARM and CHECK
//   done       high in DONE, held until the next run or reset
//   pass       done with zero errors
//   err_count  failing checks this run, saturating
//   first_err  0-based index of the first failing check (valid if err_count != 0)
module lab02_dff_checker #(
  parameter int NUM_CHECKS = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  input  logic             q,
  input  logic             qn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic             exp_bit;   // din sampled on the previous edge
  logic [CNT_W-1:0] idx;       // index of the check happening at the next edge
  logic             err_seen;  // a failure has already been recorded this run
  logic             fail;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ERR_MAX) ? v : v + CNT_W'(1);
  endfunction

`ifdef LAB02_CHK_NOUT_EN
  assign fail = (q != exp_bit) || (qn != ~q);
`else
  // qn has no role in this build; the named sink only keeps it visibly unused.
  logic unused_qn;
  assign unused_qn = qn;
  assign fail      = (q != exp_bit);
`endif

  // Next-state and output decode. The outputs depend only on registers.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ARM;
      end
      ARM: begin
        busy      = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = ARM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pass = done && (err_count == '0);

  // State register and run datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      exp_bit   <= 1'b0;
      idx       <= '0;
      err_count <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            first_err <= '0;
            err_seen  <= 1'b0;
          end
        end
        ARM: begin
          exp_bit <= din;
        end
        CHECK: begin
          if (fail) begin
            err_count <= sat_inc(err_count);
            if (!err_seen) begin
              first_err <= idx;
              err_seen  <= 1'b1;
            end
          end
          exp_bit <= din;
          // Hold on the last index so idx never passes NUM_CHECKS-1.
          if (idx != LAST_IDX) idx <= idx + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
